// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
package mem_arb_types;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Access latched onto the memory port at grant time.
    typedef struct packed {
        logic              write;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Wait counter width: enough to hold the timeout value, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = unsigned'($clog2(timeout + 1));
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
module rr_pick2
    import mem_arb_types::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant
);

    // Single requester wins outright; on contention the side not granted last wins.
    always_comb begin
        grant = REQ_I;
        if (req == 2'b11) begin
            grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req[1]) begin
            grant = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byte_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              err_timeout,
    output logic              err_rw
);

    localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_M1   = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    mem_req_t         r_req;
    mem_req_t         w_new_req;
    req_id_t          r_last_grant;
    req_id_t          w_pick;
    logic [1:0]       w_req;
    logic             w_grant_en;
    logic             w_serving;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_err_timeout;
    logic             r_err_rw;

    assign w_req = {d_read | d_write, i_read};

    rr_pick2 u_pick (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the payload to latch on a grant.
    always_comb begin
        w_next_state    = r_state;
        w_grant_en      = 1'b0;
        w_new_req.write = 1'b0;
        w_new_req.be    = '1;
        w_new_req.addr  = i_address;
        w_new_req.wdata = '0;
        if (w_pick == REQ_D) begin
            w_new_req.write = d_write;
            w_new_req.be    = d_write ? d_byte_enable : '1;
            w_new_req.addr  = d_address;
            w_new_req.wdata = d_wdata;
        end
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant_en   = 1'b1;
                    w_next_state = (w_pick == REQ_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_serving = (r_state == SERVE_I) || (r_state == SERVE_D);

    // Port strobes, latched access, round-robin history, wait counter and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_req         <= '0;
            r_last_grant  <= REQ_D;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
            r_err_rw      <= 1'b0;
        end else if (w_grant_en) begin
            r_mem_read   <= ~w_new_req.write;
            r_mem_write  <= w_new_req.write;
            r_req        <= w_new_req;
            r_last_grant <= w_pick;
            r_wait_cnt   <= '0;
            if ((w_pick == REQ_D) && d_read && d_write) begin
                r_err_rw <= 1'b1;
            end
        end else if (w_serving) begin
            if (mem_resp) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end else begin
                if (r_wait_cnt != CNT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                if (TO_EN && (r_wait_cnt >= TO_M1)) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_req.be;
    assign mem_address     = r_req.addr;
    assign mem_wdata       = r_req.wdata;
    assign err_timeout     = r_err_timeout;
    assign err_rw          = r_err_rw;

    // Completion is routed combinationally to whichever side owns the port.
    assign i_resp  = (r_state == SERVE_I) && mem_resp;
    assign d_resp  = (r_state == SERVE_D) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        err_timeout;
    logic        err_rw;

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;   // 0 = fetch, 1 = data

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_address       (i_address),
        .i_rdata         (i_rdata),
        .i_resp          (i_resp),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byte_enable   (d_byte_enable),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_resp          (d_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .err_timeout     (err_timeout),
        .err_rw          (err_rw)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called right after the grant edge; checks the whole access and leaves the arbiter idle.
    task automatic serve(input int side, input logic [31:0] addr, input logic wr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input int lat, input logic [31:0] rdata);
        chk1("grant_read", mem_read, ~wr);
        chk1("grant_write", mem_write, wr);
        chk("grant_addr", mem_address, addr);
        chk("grant_be", 32'(mem_byte_enable), 32'(be));
        if (wr) chk("grant_wdata", mem_wdata, wdata);
        for (int k = 0; k < lat; k++) begin
            mem_resp = 1'b0;
            if (side == 0) i_address = $urandom;
            else           d_address = $urandom;
            #1;
            chk1("wait_i_resp", i_resp, 1'b0);
            chk1("wait_d_resp", d_resp, 1'b0);
            cyc();
            chk("hold_addr", mem_address, addr);
            chk1("hold_strobe", mem_read | mem_write, 1'b1);
        end
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        chk1("resp_i", i_resp, side == 0);
        chk1("resp_d", d_resp, side == 1);
        chk("rdata_i", i_rdata, (side == 0) ? rdata : 32'h0);
        chk("rdata_d", d_rdata, (side == 1) ? rdata : 32'h0);
        cyc();
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        if (side == 0) begin
            i_read = 1'b0;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        chk1("idle_read", mem_read, 1'b0);
        chk1("idle_write", mem_write, 1'b0);
    endtask

    task automatic serve_side(input int side, input logic [31:0] ia, input logic [31:0] da,
                              input logic dw, input logic [3:0] dbe, input logic [31:0] dwd);
        int          lat;
        logic [31:0] rd;
        lat = $urandom_range(0, 3);
        rd  = $urandom;
        if (side == 0) serve(0, ia, 1'b0, 4'hF, 32'h0, lat, rd);
        else           serve(1, da, dw, dw ? dbe : 4'hF, dwd, lat, rd);
    endtask

    // One round: pattern 0 = fetch only, 1 = data only, 2 = both contend.
    task automatic round(input int pat, input logic dw);
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        int          first;
        ia  = $urandom;
        da  = $urandom;
        dwd = $urandom;
        dbe = 4'($urandom);
        i_address     = ia;
        d_address     = da;
        d_wdata       = dwd;
        d_byte_enable = dbe;
        i_read  = (pat != 1);
        d_read  = (pat != 0) && !dw;
        d_write = (pat != 0) && dw;
        if (pat == 2) first = (last_win == 0) ? 1 : 0;
        else          first = (pat == 0) ? 0 : 1;
        cyc();
        serve_side(first, ia, da, dw, dbe, dwd);
        last_win = first;
        if (pat == 2) begin
            cyc();
            serve_side(1 - first, ia, da, dw, dbe, dwd);
            last_win = 1 - first;
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_read        = 1'b0;
        i_address     = 32'h0;
        d_read        = 1'b0;
        d_write       = 1'b0;
        d_byte_enable = 4'h0;
        d_address     = 32'h0;
        d_wdata       = 32'h0;
        mem_rdata     = 32'h0;
        mem_resp      = 1'b0;
        last_win      = 1;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk("rst_be", 32'(mem_byte_enable), 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk1("rst_i_resp", i_resp, 1'b0);
        chk1("rst_d_resp", d_resp, 1'b0);
        chk1("rst_err_timeout", err_timeout, 1'b0);
        chk1("rst_err_rw", err_rw, 1'b0);

        // Fetch only, address changed mid-access, response 3 cycles after grant
        i_read    = 1'b1;
        i_address = 32'h60;
        cyc();
        i_address = 32'h64;
        serve(0, 32'h60, 1'b0, 4'hF, 32'h0, 3, 32'h00A00093);
        last_win = 0;

        // Store with partial byte enables
        d_write       = 1'b1;
        d_address     = 32'h100;
        d_byte_enable = 4'b0011;
        d_wdata       = 32'hDEADBEEF;
        cyc();
        serve(1, 32'h100, 1'b1, 4'b0011, 32'hDEADBEEF, 1, 32'h12345678);
        last_win = 1;

        // Contention, 4 rounds: grants alternate I, D, I, D
        repeat (4) round(2, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            round($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        chk1("rand_err_timeout", err_timeout, 1'b0);
        chk1("rand_err_rw", err_rw, 1'b0);

        // d_read and d_write together: treated as write, err_rw set
        d_read        = 1'b1;
        d_write       = 1'b1;
        d_byte_enable = 4'b0101;
        d_address     = 32'h180;
        d_wdata       = 32'hA5A5_0F0F;
        cyc();
        chk1("rw_err_set", err_rw, 1'b1);
        serve(1, 32'h180, 1'b1, 4'b0101, 32'hA5A5_0F0F, 0, 32'h0);
        last_win = 1;
        chk1("rw_err_sticky", err_rw, 1'b1);

        // Timeout: response withheld 10 cycles
        i_read    = 1'b1;
        i_address = 32'h200;
        cyc();
        chk1("to_grant", mem_read, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            mem_resp = 1'b0;
            cyc();
            chk1($sformatf("to_wait%0d", k), err_timeout, k >= int'(TO));
        end
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("to_resp", i_resp, 1'b1);
        chk("to_rdata", i_rdata, 32'hCAFE_F00D);
        cyc();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        chk1("to_sticky", err_timeout, 1'b1);
        chk1("to_idle", mem_read, 1'b0);
        last_win = 0;

        // Reset in the second SERVE_D cycle
        d_read    = 1'b1;
        d_address = 32'h300;
        cyc();
        chk1("rm_grant", mem_read, 1'b1);
        cyc();
        rst = 1'b1;
        #1;
        chk1("rm_no_d_resp_pre", d_resp, 1'b0);
        cyc();
        rst    = 1'b0;
        d_read = 1'b0;
        chk1("rm_read", mem_read, 1'b0);
        chk1("rm_write", mem_write, 1'b0);
        chk1("rm_err_timeout", err_timeout, 1'b0);
        chk1("rm_err_rw", err_rw, 1'b0);
        mem_resp = 1'b1;
        #1;
        chk1("rm_idle_d_resp", d_resp, 1'b0);
        chk1("rm_idle_i_resp", i_resp, 1'b0);
        cyc();
        mem_resp = 1'b0;
        chk1("rm_still_idle", mem_read, 1'b0);
        last_win  = 1;
        i_read    = 1'b1;
        i_address = 32'h40;
        cyc();
        serve(0, 32'h40, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D);
        last_win = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
